// File: rtl/max_pool_relu_multi.sv
// ReLU + 2x2/stride-2 max pool over D flat FP16 maps, one pooled element per clock in RUN.
// Output n is registered at the end of RUN cycle n; done follows the last write by one cycle; start is ignored while busy.
module max_pool_relu_multi #(
  parameter int D          = 6,
  parameter int H          = 28,
  parameter int W          = 28,
  parameter int DATA_WIDTH = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [D*H*W*DATA_WIDTH-1:0]            inputPool,
  output logic [D*(H/2)*(W/2)*DATA_WIDTH-1:0]    outputPool,
  output logic                                   busy,
  output logic                                   done
);
  localparam int HO = H / 2;
  localparam int WO = W / 2;
  localparam int N  = D * HO * WO;
  localparam int DB = (D  > 1) ? $clog2(D)  : 1;
  localparam int IB = (HO > 1) ? $clog2(HO) : 1;
  localparam int JB = (WO > 1) ? $clog2(WO) : 1;
  localparam int NB = (N  > 1) ? $clog2(N)  : 1;
  localparam int XB = $clog2(D * H * W * DATA_WIDTH);
  localparam int OB = $clog2(N * DATA_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state;
  logic [DB-1:0]         d_cnt;
  logic [IB-1:0]         i_cnt;
  logic [JB-1:0]         j_cnt;
  logic [NB-1:0]         n_cnt;
  logic [XB-1:0]         base;
  logic [OB-1:0]         wr_off;
  logic [DATA_WIDTH-1:0] win  [4];
  logic [DATA_WIDTH-1:0] rl   [4];
  logic [DATA_WIDTH-1:0] m01, m23, mx;

  // Bit offset of the window's top-left element; the other three are +1 column / +1 row away.
  always_comb begin
    base   = XB'(((int'(d_cnt) * H + 2 * int'(i_cnt)) * W + 2 * int'(j_cnt)) * DATA_WIDTH);
    wr_off = OB'(int'(n_cnt) * DATA_WIDTH);
  end

  always_comb begin
    win[0] = inputPool[base                          +: DATA_WIDTH];
    win[1] = inputPool[base + XB'(DATA_WIDTH)        +: DATA_WIDTH];
    win[2] = inputPool[base + XB'(W * DATA_WIDTH)    +: DATA_WIDTH];
    win[3] = inputPool[base + XB'((W+1)*DATA_WIDTH)  +: DATA_WIDTH];
    for (int k = 0; k < 4; k++) begin
      rl[k] = win[k][DATA_WIDTH-1] ? '0 : win[k];
    end
    // Non-negative FP16 values order the same as their raw bit patterns.
    m01 = (rl[1] > rl[0]) ? rl[1] : rl[0];
    m23 = (rl[3] > rl[2]) ? rl[3] : rl[2];
    mx  = (m23 > m01) ? m23 : m01;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      d_cnt      <= '0;
      i_cnt      <= '0;
      j_cnt      <= '0;
      n_cnt      <= '0;
      outputPool <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            d_cnt <= '0;
            i_cnt <= '0;
            j_cnt <= '0;
            n_cnt <= '0;
            busy  <= 1'b1;
          end
        end
        S_RUN: begin
          outputPool[wr_off +: DATA_WIDTH] <= mx;
          if (n_cnt == NB'(N - 1)) begin
            state <= S_DONE;
            busy  <= 1'b0;
          end else begin
            n_cnt <= n_cnt + 1'b1;
            if (j_cnt == JB'(WO - 1)) begin
              j_cnt <= '0;
              if (i_cnt == IB'(HO - 1)) begin
                i_cnt <= '0;
                d_cnt <= d_cnt + 1'b1;
              end else begin
                i_cnt <= i_cnt + 1'b1;
              end
            end else begin
              j_cnt <= j_cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (start) begin
            state <= S_RUN;
            d_cnt <= '0;
            i_cnt <= '0;
            j_cnt <= '0;
            n_cnt <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
          end else begin
            done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_max_pool_relu_multi.sv
// Scoreboard bench for max_pool_relu_multi: expected pooled values queued at start, popped as each output is written.
module tb_max_pool_relu_multi;
  localparam int D  = 6;
  localparam int H  = 28;
  localparam int W  = 28;
  localparam int HO = H / 2;
  localparam int WO = W / 2;
  localparam int N  = D * HO * WO;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic [D*H*W*16-1:0]   inputPool;
  logic [N*16-1:0]       outputPool;
  logic                  busy;
  logic                  done;

  logic [15:0] in_mem [D][H][W];
  logic [15:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  max_pool_relu_multi #(.D(D), .H(H), .W(W), .DATA_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .inputPool  (inputPool),
    .outputPool (outputPool),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int idx(input int d, input int i, input int j);
    return (d * HO + i) * WO + j;
  endfunction

  function automatic logic [15:0] elem(input int n);
    return outputPool[15'(16 * n) +: 16];
  endfunction

  function automatic int count_bad(input logic [N*16-1:0] ref_bus);
    int c = 0;
    for (int n = 0; n < N; n++)
      if (outputPool[15'(16 * n) +: 16] !== ref_bus[15'(16 * n) +: 16]) c++;
    return c;
  endfunction

  function automatic logic [15:0] pool_ref(input int d, input int i, input int j);
    logic [15:0] m = 16'h0000;
    logic [15:0] v;
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++) begin
        v = in_mem[d][2*i+a][2*j+b];
        if (v[15]) v = 16'h0000;
        if (v > m) m = v;
      end
    return m;
  endfunction

  task automatic pack();
    for (int d = 0; d < D; d++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          inputPool[17'(16 * ((d * H + r) * W + c)) +: 16] = in_mem[d][r][c];
  endtask

  task automatic fill_zero();
    for (int d = 0; d < D; d++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          in_mem[d][r][c] = 16'h0000;
  endtask

  task automatic fill_rand();
    for (int d = 0; d < D; d++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          in_mem[d][r][c] = 16'($urandom);
  endtask

  // restart_at / rst_at / probe_at name the RUN edge (1..N) at which to act; 0 disables.
  task automatic run_pool(input int restart_at, input int rst_at, input int probe_at);
    logic [N*16-1:0] prev;
    logic [N*16-1:0] expbus;
    logic [N*16-1:0] mixbus;
    logic [15:0]     v;
    prev   = outputPool;
    expbus = '0;
    pack();
    exp_q.delete();
    for (int d = 0; d < D; d++)
      for (int i = 0; i < HO; i++)
        for (int j = 0; j < WO; j++) begin
          v = pool_ref(d, i, j);
          exp_q.push_back(v);
          expbus[15'(16 * idx(d, i, j)) +: 16] = v;
        end
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_rise", busy, 1);
    check("done_drop", done, 0);
    for (int k = 1; k <= N; k++) begin
      if (k == restart_at) start = 1'b1;
      if (k == rst_at) reset = 1'b0;
      tick();
      start = 1'b0;
      if (k == rst_at) begin
        reset = 1'b1;
        check("rst_clear", count_bad('0), 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        exp_q.delete();
        repeat (5) tick();
        check("rst_nodone", done, 0);
        check("rst_idle_busy", busy, 0);
        return;
      end
      check("pool_val", elem(k - 1), exp_q.pop_front());
      check("busy_run", busy, (k < N) ? 1 : 0);
      if (k == probe_at) begin
        for (int n = 0; n < N; n++)
          mixbus[15'(16 * n) +: 16] = (n < k) ? expbus[15'(16 * n) +: 16] : prev[15'(16 * n) +: 16];
        check("probe_mix", count_bad(mixbus), 0);
      end
    end
    check("done_late", done, 0);
    tick();
    check("done_rise", done, 1);
    check("busy_low", busy, 0);
    check("full_bus", count_bad(expbus), 0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    fill_rand();
    pack();
    repeat (2) tick();
    check("reset_out", count_bad('0), 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    reset = 1'b1;
    repeat (20) tick();
    check("idle_out", count_bad('0), 0);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);

    // Basic window with a stray start in the middle of RUN.
    fill_zero();
    in_mem[0][0][0] = 16'h3C00;
    in_mem[0][0][1] = 16'h4000;
    in_mem[0][1][0] = 16'h3800;
    in_mem[0][1][1] = 16'h4200;
    run_pool(500, 0, 0);
    check("basic_00", elem(0), 16'h4200);
    check("basic_01", elem(1), 16'h0000);

    // Sign handling, subnormal vs -0, and NaN/Inf ordering; started from DONE.
    fill_zero();
    in_mem[1][4][6]   = 16'hBC00; in_mem[1][4][7]   = 16'hC000;
    in_mem[1][5][6]   = 16'h8000; in_mem[1][5][7]   = 16'hFBFF;
    in_mem[2][10][12] = 16'h8000; in_mem[2][10][13] = 16'h0001;
    in_mem[2][11][12] = 16'hBC00; in_mem[2][11][13] = 16'h0000;
    in_mem[3][0][0]   = 16'h7C00; in_mem[3][0][1]   = 16'h7E00;
    in_mem[3][1][0]   = 16'h7BFF; in_mem[3][1][1]   = 16'hFE00;
    run_pool(0, 0, 0);
    check("relu_neg", elem(idx(1, 2, 3)), 16'h0000);
    check("subnorm", elem(idx(2, 5, 6)), 16'h0001);
    check("nan_max", elem(idx(3, 0, 0)), 16'h7E00);

    // Ordering: each input holds its own flat index.
    for (int d = 0; d < D; d++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          in_mem[d][r][c] = 16'(((d * H + r) * W + c) & 16'h7FFF);
    run_pool(0, 0, 400);
    check("order_000", elem(idx(0, 0, 0)), 16'(((0 * H + 1) * W + 1) & 16'h7FFF));
    check("order_3_7_2", elem(idx(3, 7, 2)), 16'(((3 * H + 15) * W + 5) & 16'h7FFF));
    check("order_last", elem(idx(5, 13, 13)), 16'(((5 * H + 27) * W + 27) & 16'h7FFF));

    // Reset in the middle of RUN, then a clean random run.
    fill_rand();
    run_pool(0, 300, 0);
    fill_rand();
    run_pool(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
